// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache
// answering the LSQ data port over a word-wide backing bus.
module dcache_responder #(
  parameter int NUM_SETS       = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic        dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  output logic        bmem_write,
  output logic [3:0]  bmem_wmask,
  output logic [31:0] bmem_wdata,
  input  logic [31:0] bmem_rdata,
  input  logic        bmem_resp
);

  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 30 - OW - IW;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    RESP
  } state_t;

  state_t state, state_n;

  logic [NUM_SETS-1:0] valid;
  logic [TW-1:0]       tags [NUM_SETS];
  logic [31:0]         data [NUM_SETS][WORDS_PER_LINE];
  logic [31:0]         lbuf [WORDS_PER_LINE];

  logic [31:2] req_addr;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata;
  logic [OW-1:0] beat;
  logic        gap;
  logic [31:0] rdata_q;

  logic [OW-1:0] in_off, rq_off;
  logic [IW-1:0] in_idx, rq_idx;
  logic [TW-1:0] in_tag, rq_tag;
  logic in_hit, rq_hit;
  logic is_wr, is_rd;
  logic last_beat, beat_done;
  logic [31:0] fill_word, merged;
  logic unused_addr;

  // Byte offset within the word never matters: all traffic is word-wide.
  assign unused_addr = ^dmem_addr[1:0];

  assign in_off = dmem_addr[2 +: OW];
  assign in_idx = dmem_addr[2+OW +: IW];
  assign in_tag = dmem_addr[31 -: TW];
  assign rq_off = req_addr[2 +: OW];
  assign rq_idx = req_addr[2+OW +: IW];
  assign rq_tag = req_addr[31 -: TW];

  assign in_hit = valid[in_idx] && (tags[in_idx] == in_tag);
  assign rq_hit = valid[rq_idx] && (tags[rq_idx] == rq_tag);

  assign is_wr = |dmem_wmask;
  assign is_rd = dmem_rmask & ~is_wr;

  assign last_beat = (beat == OW'(WORDS_PER_LINE - 1));
  assign beat_done = (state == FILL) && bmem_read && bmem_resp;

  // The final beat is not in the buffer yet, so forward it.
  assign fill_word = (rq_off == beat) ? bmem_rdata : lbuf[rq_off];

  assign dmem_rdata = rdata_q;

  // Byte-merge the store into the cached word on a write hit.
  always_comb begin
    merged = data[rq_idx][rq_off];
    for (int b = 0; b < 4; b++) begin
      if (req_wmask[b]) merged[8*b +: 8] = req_wdata[8*b +: 8];
    end
  end

  // Next-state and bus outputs; backing outputs idle at zero.
  always_comb begin
    state_n    = state;
    dmem_resp  = 1'b0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wmask = '0;
    bmem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (is_wr) state_n = WRITE;
        else if (is_rd) state_n = in_hit ? RESP : FILL;
      end
      FILL: begin
        bmem_read = ~gap;
        bmem_addr = {req_addr[31:2+OW], beat, 2'b00};
        if (~gap && bmem_resp && last_beat) state_n = RESP;
      end
      WRITE: begin
        bmem_write = 1'b1;
        bmem_addr  = {req_addr, 2'b00};
        bmem_wmask = req_wmask;
        bmem_wdata = req_wdata;
        if (bmem_resp) state_n = RESP;
      end
      RESP: begin
        dmem_resp = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state, request latch, fill sequencing and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      req_addr  <= '0;
      req_wmask <= '0;
      req_wdata <= '0;
      beat      <= '0;
      gap       <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state <= state_n;
      gap   <= 1'b0;
      if (state == IDLE && (is_wr || is_rd)) begin
        req_addr  <= dmem_addr[31:2];
        req_wmask <= dmem_wmask;
        req_wdata <= dmem_wdata;
        beat      <= '0;
      end
      if (state == IDLE && is_rd && in_hit) begin
        rdata_q <= data[in_idx][in_off];
      end
      if (beat_done) begin
        beat <= beat + 1'b1;
        gap  <= 1'b1;
        if (last_beat) begin
          valid[rq_idx] <= 1'b1;
          rdata_q       <= fill_word;
        end
      end
    end
  end

  // Line storage: fill buffer, line install, store merge.
  always_ff @(posedge clk) begin
    if (!rst && beat_done) begin
      lbuf[beat] <= bmem_rdata;
      if (last_beat) begin
        tags[rq_idx] <= rq_tag;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
          data[rq_idx][w] <= (OW'(w) == beat) ? bmem_rdata : lbuf[w];
        end
      end
    end
    if (!rst && state == WRITE && bmem_resp && rq_hit) begin
      data[rq_idx][rq_off] <= merged;
    end
  end

endmodule
